seven_segment_scan_driver: RTL and testbench
============================================

// Module: seven_segment_scan_driver
// PURPOSE
// - Parametrised successor to the team's 4-digit seven-segment controller.
// - Time-multiplexes NUM_DIGITS digits onto a common-anode display
//   (Basys3-style, all outputs active-low).
// - Takes a loadable value plus per-digit decimal points.
// - Adds hex/BCD mode, an inter-digit ghost-blanking cycle and a global
//   enable.
// - Sits between the application datapath and the board display pins.
// PARAMETERS
// - NUM_DIGITS   4        digits scanned, legal 1..8
// - REFRESH_DIV  100000   clocks per digit slot (1 ms at 100 MHz), legal >= 2
// - HEX_MODE     1        1: nibbles A-F shown as hex; 0: nibble > 9 shown as dash
// PORTS
// - clk_100MHz  in   1                single system clock, all logic on rising edge
// - reset       in   1                synchronous, active-high
// - value_in    in   4*NUM_DIGITS     display value, digit i = value_in[4i+3:4i], digit 0 rightmost
// - dp_in       in   NUM_DIGITS       1 = light decimal point of digit i
// - load        in   1                1 = capture value_in/dp_in into shadow regs this edge
// - enable      in   1                0 = display dark, scan frozen
// - anode       out  NUM_DIGITS       active-low digit select, one-cold
// - segment     out  7                active-low {g,f,e,d,c,b,a}
// - dp          out  1                active-low decimal point of selected digit
// - digit_idx   out  $clog2(NUM_DIGITS) (min 1)  index of digit currently driven
// BEHAVIOUR
// - Reset (synchronous, overrides everything):
//   - anode all 1; segment 7'h7F; dp 1; digit_idx 0.
//   - Shadow value/dp 0; prescaler 0; blank flag 0.
//   - Reset mid-scan returns to this state on the next edge.
// - Shadow registers:
//   - Updated on any edge with load=1, independent of enable and scan state.
//   - Outputs reflect new shadow contents on the edge after the load edge.
//   - anode is unchanged by load.
// - Prescaler:
//   - Counts 0..REFRESH_DIV-1 while enable=1; terminal count = tick.
//   - On tick, digit_idx advances; it wraps NUM_DIGITS-1 -> 0.
// - Slot structure (REFRESH_DIV clocks per slot):
//   - After each tick edge, anode = all 1 and segment = 7'h7F for exactly 1
//     clock (ghost blank).
//   - anode[digit_idx] = 0 for the remaining REFRESH_DIV-1 clocks.
//   - Full frame = NUM_DIGITS*REFRESH_DIV clocks.
// - enable=0:
//   - Prescaler and digit_idx hold.
//   - Next edge: anode all 1, segment 7'h7F, dp 1.
//   - On re-enable, scanning resumes from the held count/index; there is no
//     blank cycle unless a tick occurs.
// - Decode (active-low gfedcba):
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010,
//     6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
//   - HEX_MODE=0: nibbles A-F show dash = 0111111.
// - dp = ~shadow_dp[digit_idx] while a digit is driven; 1 during blank and
//   disabled cycles.
// - All outputs registered; no combinational input-to-output path.
// - Single-digit build (NUM_DIGITS=1): digit_idx stays 0.
// - Out-of-range parameters are a $fatal at elaboration.
// CONFIGURATION
// - Macro SEVSEG_LEADING_ZERO_BLANK_EN.
// - Defined: a digit i>0 is dark (its anode still pulses, segment 7'h7F)
//   when all of the following hold:
//   - its shadow nibble and all higher nibbles are 0;
//   - its dp bit and all higher dp bits are 0.
// - Digit 0 is always shown.
// - Undefined: every digit always shows its decoded nibble.
// TESTING (bench uses REFRESH_DIV=4, NUM_DIGITS=4 unless stated)
// - Reset held 3 clocks mid-scan -> anode=1111, segment=1111111, dp=1,
//   digit_idx=0 on the first edge of reset.
// - load value_in=16'h1234, dp_in=0 -> digit0 slot: anode=1110,
//   segment=0011001. Then 1-clock blank (1111). Then anode=1101,
//   segment=0110000. Frame repeats every 16 clocks.
// - load mid-slot with 16'h123F while digit0 driven -> next edge
//   segment=0001110, anode stays 1110. HEX_MODE=0 instance shows 0111111
//   instead.
// - enable=0 for 10 clocks mid-slot of digit 2 -> anode=1111 from next edge,
//   digit_idx holds 2. Re-enable -> digit 2 finishes its remaining slot count.
// - value 16'h0050, dp_in=0:
//   - macro defined -> digits 3,2 segment=1111111; digit1 0010010;
//     digit0 1000000.
//   - macro undefined -> digits 3,2 show 1000000.
// - dp_in=4'b0100 with value 16'h0050 -> digit2 lit as '0' with dp=0 under
//   the macro; wrap digit 3 -> 0 verified over 3 frames.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed common-anode seven-segment
// driver with shadowed value/dp, hex or BCD-style decode, a one-clock ghost
// blank after every digit advance, and a global enable. All outputs are
// active-low and registered.
// Optional build macro: SEVSEG_LEADING_ZERO_BLANK_EN darkens leading zero
// digits (digit 0 always shown; a lit dp keeps its digit visible).

// Per-digit nibble decoder, active-low {g,f,e,d,c,b,a}.
module seven_segment_digit_decode #(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  // Nibble to glyph lookup; letters collapse to a dash when hex is off.
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
      4'hB: seg = (HEX_MODE != 0) ? 7'h03 : 7'h3F;
      4'hC: seg = (HEX_MODE != 0) ? 7'h46 : 7'h3F;
      4'hD: seg = (HEX_MODE != 0) ? 7'h21 : 7'h3F;
      4'hE: seg = (HEX_MODE != 0) ? 7'h06 : 7'h3F;
      default: seg = (HEX_MODE != 0) ? 7'h0E : 7'h3F;
    endcase
  end
endmodule

module seven_segment_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 1
) (
  input  logic                                             clk_100MHz,
  input  logic                                             reset,
  input  logic [4*NUM_DIGITS-1:0]                          value_in,
  input  logic [NUM_DIGITS-1:0]                            dp_in,
  input  logic                                             load,
  input  logic                                             enable,
  output logic [NUM_DIGITS-1:0]                            anode,
  output logic [6:0]                                       segment,
  output logic                                             dp,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 ||
        (HEX_MODE != 0 && HEX_MODE != 1)) begin : g_bad_param
      $fatal(1, "seven_segment_scan_driver: parameter out of range");
    end
  endgenerate

  logic [NUM_DIGITS-1:0][3:0] shadow_val;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      dark;
  logic [CNT_W-1:0]           cnt;
  logic                       tick;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  // One decoder per digit, all fed from the shadow registers.
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
      seven_segment_digit_decode #(.HEX_MODE(HEX_MODE)) u_dec (
        .nibble (shadow_val[g]),
        .seg    (lane_seg[g])
      );
    end
  endgenerate

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is dark while it and everything
  // above it is zero with no dp lit. Digit 0 is never darkened.
  always_comb begin
    logic hz;
    dark = '0;
    hz   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hz      = hz & (shadow_val[i] == 4'h0) & ~shadow_dp[i];
      dark[i] = hz;
    end
  end
`else
  assign dark = '0;
`endif

  // Shadow capture: load wins on any edge regardless of scan/enable state.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value_in;
      shadow_dp  <= dp_in;
    end
  end

  // Prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt       <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output registers: blank on tick (ghost blank) and while disabled,
  // otherwise drive the current digit from the shadow contents.
  always_ff @(posedge clk_100MHz) begin
    if (reset || !enable || tick) begin
      anode   <= '1;
      segment <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      anode   <= ~(NUM_DIGITS'(1) << digit_idx);
      segment <= dark[digit_idx] ? 7'h7F : lane_seg[digit_idx];
      dp      <= ~shadow_dp[digit_idx];
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4): a hex
// instance and a HEX_MODE=0 instance share all inputs. A cycle-level model
// derives the scan position from the count of enabled edges since reset.
module tb_seven_segment_scan_driver;
  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load, enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  anode, anode_h0;
  logic [6:0]  segment, segment_h0;
  logic        dp, dp_h0;
  logic [1:0]  digit_idx, digit_idx_h0;

  seven_segment_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1)) dut (
    .clk_100MHz(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
    .load(load), .enable(enable), .anode(anode), .segment(segment),
    .dp(dp), .digit_idx(digit_idx));

  seven_segment_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0)) dut_h0 (
    .clk_100MHz(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
    .load(load), .enable(enable), .anode(anode_h0), .segment(segment_h0),
    .dp(dp_h0), .digit_idx(digit_idx_h0));

  int n_pass  = 0;
  int n_total = 0;

  // Model state: enabled edges since reset plus the captured shadows.
  int          m_e;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [6:0]  seg_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] exp_seg(input int dig, input bit hex);
    int nib;
    nib = int'((m_val >> (4 * dig)) & 16'hF);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    if (dig > 0 && (m_val >> (4 * dig)) == 0 && (m_dp >> dig) == 0) return 7'h7F;
`endif
    if (!hex && nib > 9) return 7'h3F;
    return seg_tab[nib];
  endfunction

  // One clock: model the edge, then compare every output half a cycle later.
  task automatic step(input string tag);
    logic [3:0] ea, one;
    logic [6:0] es, es0;
    logic       ed;
    int         pos, dig;
    one = 4'b0001;
    @(posedge clk);
    ea = 4'hF; es = 7'h7F; es0 = 7'h7F; ed = 1'b1;
    if (reset) begin
      m_e = 0; m_val = '0; m_dp = '0;
    end else begin
      if (enable) begin
        pos = m_e % R;
        dig = (m_e / R) % N;
        if (pos != R - 1) begin
          ea  = ~(one << dig);
          es  = exp_seg(dig, 1'b1);
          es0 = exp_seg(dig, 1'b0);
          ed  = ~m_dp[dig];
        end
        m_e++;
      end
      if (load) begin m_val = value_in; m_dp = dp_in; end
    end
    @(negedge clk);
    chk({tag, " anode"}, 32'(anode), 32'(ea));
    chk({tag, " segment"}, 32'(segment), 32'(es));
    chk({tag, " dp"}, 32'(dp), 32'(ed));
    chk({tag, " digit_idx"}, 32'(digit_idx), 32'((m_e / R) % N));
    chk({tag, " segment_h0"}, 32'(segment_h0), 32'(es0));
    chk({tag, " anode_h0"}, 32'(anode_h0), 32'(ea));
  endtask

  task automatic restart_with(input logic [15:0] v, input logic [3:0] d);
    reset = 1'b1; load = 1'b0; enable = 1'b1;
    step("rst");
    reset = 1'b0; value_in = v; dp_in = d; load = 1'b1;
    step("load");
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    int          dig;
    logic [6:0]  seg_plain;
    logic [6:0]  seg_lz;
    logic        dp_exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [3:0] one, ea;
    logic [6:0] es;
    logic [1:0] prev;
    int         wraps;
    one = 4'b0001;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h1234, 4'b0000, 0, 7'h19, 7'h19, 1'b1};
    vecs[1] = '{16'h1234, 4'b0000, 1, 7'h30, 7'h30, 1'b1};
    vecs[2] = '{16'h0050, 4'b0000, 3, 7'h40, 7'h7F, 1'b1};
    vecs[3] = '{16'h0050, 4'b0000, 2, 7'h40, 7'h7F, 1'b1};
    vecs[4] = '{16'h0050, 4'b0000, 1, 7'h12, 7'h12, 1'b1};
    vecs[5] = '{16'h0050, 4'b0000, 0, 7'h40, 7'h40, 1'b1};
    vecs[6] = '{16'h0050, 4'b0100, 2, 7'h40, 7'h40, 1'b0};
    vecs[7] = '{16'h0050, 4'b0100, 3, 7'h40, 7'h7F, 1'b1};
    vecs[8] = '{16'h0000, 4'b0000, 0, 7'h40, 7'h40, 1'b1};
    vecs[9] = '{16'hABCD, 4'b1000, 3, 7'h08, 7'h08, 1'b0};

    reset = 1'b1; load = 1'b0; enable = 1'b1; value_in = '0; dp_in = '0;
    step("init");

    // Reset held for 3 clocks in the middle of a scan.
    restart_with(16'h1234, 4'b0000);
    repeat (9) step("prerst");
    reset = 1'b1;
    step("rst1");
    chk("rst anode", 32'(anode), 32'h0000000F);
    chk("rst segment", 32'(segment), 32'h0000007F);
    chk("rst dp", 32'(dp), 32'd1);
    chk("rst digit_idx", 32'(digit_idx), 32'd0);
    step("rst2");
    step("rst3");
    reset = 1'b0;

    // Table: land on the second driven edge of the chosen digit's slot.
    for (int i = 0; i < 10; i++) begin
      restart_with(vecs[i].val, vecs[i].dpv);
      repeat (vecs[i].dig * R + 1) step("vec");
      ea = ~(one << vecs[i].dig);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      es = vecs[i].seg_lz;
`else
      es = vecs[i].seg_plain;
`endif
      chk($sformatf("tbl%0d segment", i), 32'(segment), 32'(es));
      chk($sformatf("tbl%0d anode", i), 32'(anode), 32'(ea));
      chk($sformatf("tbl%0d dp", i), 32'(dp), 32'(vecs[i].dp_exp));
    end

    // Slot shape for 1234: digit0, ghost blank, then digit1.
    restart_with(16'h1234, 4'b0000);
    step("frm");
    chk("frm d0 anode", 32'(anode), 32'hE);
    chk("frm d0 seg", 32'(segment), 32'h19);
    step("frm");
    step("frm");
    chk("frm blank anode", 32'(anode), 32'hF);
    chk("frm blank seg", 32'(segment), 32'h7F);
    step("frm");
    chk("frm d1 anode", 32'(anode), 32'hD);
    chk("frm d1 seg", 32'(segment), 32'h30);

    // Load mid-slot while digit 0 is driven.
    restart_with(16'h1234, 4'b0000);
    value_in = 16'h123F; load = 1'b1;
    step("mid");
    load = 1'b0;
    step("mid");
    chk("midload seg", 32'(segment), 32'h0E);
    chk("midload anode", 32'(anode), 32'hE);
    chk("midload seg_h0", 32'(segment_h0), 32'h3F);

    // Disable for 10 clocks in the middle of digit 2's slot.
    restart_with(16'h1234, 4'b0000);
    repeat (8) step("en");
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step("dis");
      chk("dis anode", 32'(anode), 32'hF);
      chk("dis idx", 32'(digit_idx), 32'd2);
    end
    enable = 1'b1;
    step("reen");
    chk("reen anode", 32'(anode), 32'hB);
    chk("reen seg", 32'(segment), 32'h24);
    step("reen");
    chk("reen anode2", 32'(anode), 32'hB);
    step("reen");
    chk("reen blank", 32'(anode), 32'hF);
    chk("reen idx", 32'(digit_idx), 32'd3);

    // Three full frames: digit 3 -> 0 wrap seen exactly three times.
    restart_with(16'h0050, 4'b0100);
    prev = digit_idx;
    wraps = 0;
    repeat (3 * N * R) begin
      step("wrap");
      if (prev == 2'd3 && digit_idx == 2'd0) wraps++;
      prev = digit_idx;
    end
    chk("wrap count", 32'(wraps), 32'd3);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      reset  = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) begin
        value_in = 16'($urandom) & 16'h00FF;
        dp_in    = 4'($urandom) & 4'b0011;
      end else begin
        value_in = 16'($urandom);
        dp_in    = 4'($urandom);
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
